pipe_reg_ctrl: RTL and testbench

- Consumer end of the dual-lane hazard interface.
- Takes the per-lane stall/flush masks produced by hazard detection, plus branch redirects and external memory stalls.
- Drives per-stage enable and clear strobes for both lanes' pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
- Owns the registered `first` lane-order bit that the hazard unit consumes, and a stall watchdog.

---
 rtl/pipe_reg_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_pipe_reg_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_reg_ctrl
//   Consumer end of the dual-lane hazard interface. It turns the per-lane
//   stall/flush masks, a taken-branch redirect and an external memory stall
//   into load-enable and clear-to-NOP strobes for both lanes' pipeline
//   registers. It also owns the registered `first` lane-order bit and a
//   sticky stall watchdog.
//
//   Mask bit order: 0 = PC, 1 = IF/ID, 2 = ID/EX, 3 = EX/MEM, 4 = MEM/WB.
//
//   Ports
//     clk            rising-edge clock
//     reset_n        asynchronous active-low reset
//     stall0/flush0  lane0 hold / bubble requests
//     stall1/flush1  lane1 hold / bubble requests
//     branch_flush   taken-branch redirect resolved in EX
//     ext_stall      memory busy, freezes the whole pipe
//     en0/clr0       lane0 register load enables / clear-to-NOP (combinational)
//     en1/clr1       lane1 register load enables / clear-to-NOP (combinational)
//     first          registered, 1 = lane1 holds the older IF/ID instruction
//     deadlock       sticky watchdog flag
//     conflict       sticky flag, same stage both stalled and flushed
//     stall_cycles   performance counter (PC-stall cycles)
//     split_count    performance counter (single-lane splits)
//
//   Build option: define PIPE_REG_CTRL_PERF_EN to build the two performance
//   counters; otherwise both counter outputs are tied to zero.
// ---------------------------------------------------------------------------
module pipe_reg_ctrl #(
    parameter int NUM_PIPE_MASKS = 5,
    parameter int MAX_STALL      = 15,
    parameter int CNT_W          = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_PIPE_MASKS-1:0] stall0,
    input  logic [NUM_PIPE_MASKS-1:0] flush0,
    input  logic [NUM_PIPE_MASKS-1:0] stall1,
    input  logic [NUM_PIPE_MASKS-1:0] flush1,
    input  logic                      branch_flush,
    input  logic                      ext_stall,
    output logic [NUM_PIPE_MASKS-1:0] en0,
    output logic [NUM_PIPE_MASKS-1:0] clr0,
    output logic [NUM_PIPE_MASKS-1:0] en1,
    output logic [NUM_PIPE_MASKS-1:0] clr1,
    output logic                      first,
    output logic                      deadlock,
    output logic                      conflict,
    output logic [CNT_W-1:0]          stall_cycles,
    output logic [CNT_W-1:0]          split_count
);

    localparam int PC_BIT    = 0;
    localparam int IF_ID_BIT = 1;
    localparam int ID_EX_BIT = 2;
    localparam int WD_W      = $clog2(MAX_STALL + 1);

    localparam logic [WD_W-1:0] WD_MAX = WD_W'(MAX_STALL);
    localparam logic [NUM_PIPE_MASKS-1:0] MASK_ONE = NUM_PIPE_MASKS'(1);
    // A redirect squashes the two younger stages holding wrong-path work.
    localparam logic [NUM_PIPE_MASKS-1:0] BRANCH_CLR =
        (MASK_ONE << IF_ID_BIT) | (MASK_ONE << ID_EX_BIT);

    logic            hazard_sel_s;
    logic            split0_s;
    logic            split1_s;
    logic            conflict_hit_s;
    logic            wd_qual_s;
    logic [WD_W-1:0] wd_next_s;
    logic [WD_W-1:0] wd_cnt_r;
    logic            first_r;
    logic            deadlock_r;
    logic            conflict_r;

    // Hazard masks only matter when neither freeze nor redirect is active.
    assign hazard_sel_s = ~ext_stall & ~branch_flush;

    // A lane is split when it holds IF/ID while the other lane bubbles it out.
    assign split0_s = hazard_sel_s & stall0[IF_ID_BIT] & ~stall1[IF_ID_BIT] & flush1[IF_ID_BIT];
    assign split1_s = hazard_sel_s & stall1[IF_ID_BIT] & ~stall0[IF_ID_BIT] & flush0[IF_ID_BIT];

    assign conflict_hit_s = hazard_sel_s &
                            ((|(stall0 & flush0)) | (|(stall1 & flush1)) | (split0_s & split1_s));

    // Enable/clear decode in priority order: reset, freeze, redirect, masks.
    always_comb begin
        en0  = '0;
        clr0 = '0;
        en1  = '0;
        clr1 = '0;
        if (!reset_n) begin
            en0  = '0;
            clr0 = '1;
            en1  = '0;
            clr1 = '1;
        end else if (ext_stall) begin
            en0  = '0;
            clr0 = '0;
            en1  = '0;
            clr1 = '0;
        end else if (branch_flush) begin
            en0  = '1;
            clr0 = BRANCH_CLR;
            en1  = '1;
            clr1 = BRANCH_CLR;
        end else begin
            // Stall wins over flush: a held register must keep its content.
            en0  = ~stall0;
            clr0 = flush0 & ~stall0;
            en1  = ~stall1;
            clr1 = flush1 & ~stall1;
        end
    end

    // Both PCs frozen is the cycle the watchdog counts (freeze included).
    assign wd_qual_s = ~en0[PC_BIT] & ~en1[PC_BIT];

    // Next watchdog count: saturating increment on a stalled cycle, else clear.
    always_comb begin
        wd_next_s = '0;
        if (!wd_qual_s) begin
            wd_next_s = '0;
        end else if (wd_cnt_r == WD_MAX) begin
            wd_next_s = wd_cnt_r;
        end else begin
            wd_next_s = wd_cnt_r + WD_W'(1);
        end
    end

    // Lane order, watchdog and sticky flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            first_r    <= 1'b1;
            deadlock_r <= 1'b0;
            conflict_r <= 1'b0;
            wd_cnt_r   <= '0;
        end else begin
            wd_cnt_r <= wd_next_s;
            if (wd_next_s == WD_MAX) begin
                deadlock_r <= 1'b1;
            end
            if (conflict_hit_s) begin
                conflict_r <= 1'b1;
            end
            // A simultaneous double split is a conflict and leaves order alone.
            if (ext_stall) begin
                first_r <= first_r;
            end else if (branch_flush) begin
                first_r <= 1'b1;
            end else if (split0_s && !split1_s) begin
                first_r <= 1'b0;
            end else if (split1_s && !split0_s) begin
                first_r <= 1'b1;
            end else begin
                first_r <= first_r;
            end
        end
    end

    assign first    = first_r;
    assign deadlock = deadlock_r;
    assign conflict = conflict_r;

`ifdef PIPE_REG_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cycles_r;
    logic [CNT_W-1:0] split_count_r;

    // Saturating performance counters; a redirect does not clear them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles_r <= '0;
            split_count_r  <= '0;
        end else begin
            if (wd_qual_s && (stall_cycles_r != {CNT_W{1'b1}})) begin
                stall_cycles_r <= stall_cycles_r + CNT_W'(1);
            end
            if ((split0_s ^ split1_s) && (split_count_r != {CNT_W{1'b1}})) begin
                split_count_r <= split_count_r + CNT_W'(1);
            end
        end
    end

    assign stall_cycles = stall_cycles_r;
    assign split_count  = split_count_r;
`else
    assign stall_cycles = '0;
    assign split_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_reg_ctrl.sv
module tb_pipe_reg_ctrl;

    localparam int N  = 5;
    localparam int CW = 16;

    localparam logic [N-1:0] Z = 5'b00000;
    localparam logic [N-1:0] F = 5'b11111;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [N-1:0]  stall0, flush0, stall1, flush1;
    logic          branch_flush, ext_stall;
    logic [N-1:0]  en0, clr0, en1, clr1;
    logic          first, deadlock, conflict;
    logic [CW-1:0] stall_cycles, split_count;

    pipe_reg_ctrl #(.NUM_PIPE_MASKS(N), .MAX_STALL(15), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n),
        .stall0(stall0), .flush0(flush0), .stall1(stall1), .flush1(flush1),
        .branch_flush(branch_flush), .ext_stall(ext_stall),
        .en0(en0), .clr0(clr0), .en1(en1), .clr1(clr1),
        .first(first), .deadlock(deadlock), .conflict(conflict),
        .stall_cycles(stall_cycles), .split_count(split_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [54:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_sc = 0;
    int   exp_spl = 0;

    // Apply one vector just after a rising edge and queue the expected view.
    task automatic drive(input string name, input logic rn,
                         input logic [N-1:0] s0, input logic [N-1:0] f0,
                         input logic [N-1:0] s1, input logic [N-1:0] f1,
                         input logic bf, input logic xs,
                         input logic [N-1:0] e_en0, input logic [N-1:0] e_clr0,
                         input logic [N-1:0] e_en1, input logic [N-1:0] e_clr1,
                         input logic e_first, input logic e_dl, input logic e_cf,
                         input logic inc_split);
        exp_t e;
        @(posedge clk);
        #1;
        reset_n = rn; stall0 = s0; flush0 = f0; stall1 = s1; flush1 = f1;
        branch_flush = bf; ext_stall = xs;
        if (!rn) begin
            exp_sc  = 0;
            exp_spl = 0;
        end
        e.name = name;
        e.exp  = {e_en0, e_clr0, e_en1, e_clr1, e_first, e_dl, e_cf,
                  CW'(exp_sc), CW'(exp_spl)};
        sb_q.push_back(e);
`ifdef PIPE_REG_CTRL_PERF_EN
        if (rn && !e_en0[0] && !e_en1[0]) exp_sc++;
        if (rn && inc_split) exp_spl++;
`endif
    endtask

    // Free-running cycle with no hazards.
    task automatic idle(input string name, input logic e_first, input logic e_dl, input logic e_cf);
        drive(name, 1'b1, Z, Z, Z, Z, 1'b0, 1'b0, F, Z, F, Z, e_first, e_dl, e_cf, 1'b0);
    endtask

    // Monitor: pops one expectation per presented vector, mid-cycle.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t        e;
            logic [54:0] act;
            e   = sb_q.pop_front();
            act = {en0, clr0, en1, clr1, first, deadlock, conflict, stall_cycles, split_count};
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: actual=%h required=%h", e.name, act, e.exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0;
        stall0 = Z; flush0 = Z; stall1 = Z; flush1 = Z;
        branch_flush = 1'b0; ext_stall = 1'b0;

        // Reset: inputs toggle but outputs stay in the reset shape.
        drive("rst_a", 1'b0, 5'b10101, 5'b01010, F, 5'b00001, 1'b1, 1'b0, Z, F, Z, F, 1'b1, 1'b0, 1'b0, 1'b0);
        drive("rst_b", 1'b0, F, F, Z, Z, 1'b0, 1'b1, Z, F, Z, F, 1'b1, 1'b0, 1'b0, 1'b0);
        idle("rel_idle", 1'b1, 1'b0, 1'b0);

        // Lane0 split, then order flips to 0.
        drive("split0", 1'b1, 5'b00011, 5'b00100, 5'b00001, 5'b00010, 1'b0, 1'b0,
              5'b11100, 5'b00100, 5'b11110, 5'b00010, 1'b1, 1'b0, 1'b0, 1'b1);
        idle("after_split0", 1'b0, 1'b0, 1'b0);

        // Branch overrides hazard masks and restores first=1.
        drive("branch", 1'b1, 5'b00011, Z, Z, Z, 1'b1, 1'b0,
              F, 5'b00110, F, 5'b00110, 1'b0, 1'b0, 1'b0, 1'b0);
        idle("after_branch", 1'b1, 1'b0, 1'b0);

        // Lane0 split (no PC stall), then lane1 split.
        drive("split0b", 1'b1, 5'b00010, Z, Z, 5'b00010, 1'b0, 1'b0,
              5'b11101, Z, F, 5'b00010, 1'b1, 1'b0, 1'b0, 1'b1);
        drive("split1", 1'b1, Z, 5'b00010, 5'b00010, Z, 1'b0, 1'b0,
              F, 5'b00010, 5'b11101, Z, 1'b0, 1'b0, 1'b0, 1'b1);
        idle("after_split1", 1'b1, 1'b0, 1'b0);

        // Stall and flush on the same bit: stall wins, conflict sticks.
        drive("conflict", 1'b1, Z, Z, 5'b00100, 5'b00100, 1'b0, 1'b0,
              F, Z, 5'b11011, Z, 1'b1, 1'b0, 1'b0, 1'b0);
        idle("conflict_set", 1'b1, 1'b0, 1'b1);
        idle("conflict_sticky", 1'b1, 1'b0, 1'b1);

        // Watchdog: 14 stalls, one free cycle, 14 stalls, never deadlocks.
        for (int i = 0; i < 14; i++)
            drive("wd_run_a", 1'b1, 5'b00001, Z, 5'b00001, Z, 1'b0, 1'b0,
                  5'b11110, Z, 5'b11110, Z, 1'b1, 1'b0, 1'b1, 1'b0);
        idle("wd_free", 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 14; i++)
            drive("wd_run_b", 1'b1, 5'b00001, Z, 5'b00001, Z, 1'b0, 1'b0,
                  5'b11110, Z, 5'b11110, Z, 1'b1, 1'b0, 1'b1, 1'b0);
        idle("wd_no_deadlock", 1'b1, 1'b0, 1'b1);

        // Set first=0, then freeze for 15 cycles with split/branch inputs that
        // would move first if the freeze did not win.
        drive("split0c", 1'b1, 5'b00010, Z, Z, 5'b00010, 1'b0, 1'b0,
              5'b11101, Z, F, 5'b00010, 1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 15; i++)
            drive("ext_freeze", 1'b1, Z, 5'b00010, 5'b00010, Z, 1'(i % 2), 1'b1,
                  Z, Z, Z, Z, 1'b0, 1'b0, 1'b1, 1'b0);
        idle("deadlock_set", 1'b0, 1'b1, 1'b1);
        idle("deadlock_sticky", 1'b0, 1'b1, 1'b1);

        // Reset asserted in the middle of a stall restarts everything.
        for (int i = 0; i < 3; i++)
            drive("pre_reset_stall", 1'b1, 5'b00001, Z, 5'b00001, Z, 1'b0, 1'b0,
                  5'b11110, Z, 5'b11110, Z, 1'b0, 1'b1, 1'b1, 1'b0);
        drive("mid_reset", 1'b0, 5'b00001, Z, 5'b00001, Z, 1'b0, 1'b0,
              Z, F, Z, F, 1'b1, 1'b0, 1'b0, 1'b0);
        idle("post_reset", 1'b1, 1'b0, 1'b0);
        idle("post_reset_2", 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        if (sb_q.size() > 0) begin
            errors++;
            $display("FAIL drain: actual=%0d pending required=0", sb_q.size());
        end
        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
